register_bist: RTL and testbench
================================

REGISTER_BIST -- requirements
Module: register_bist

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: d_in  input  4  functional write data.
REQ-004 SHALL have port: bist_on  input  1  1 = run/hold self-test; 0 = functional mode.
REQ-005 SHALL have port: inj_sa0  input  4  test-only fault injection; bit i=1 forces register bit i stuck-at-0 on every load; tie to 0 in normal use.
REQ-006 SHALL have port: d_out  output  4  current register contents (registered, never combinational from d_in).
REQ-007 SHALL have port: pass  output  1  1 = last completed self-test found no mismatch.
REQ-008 SHALL have port: bist_done  output  1  1 = a self-test has completed and its result is valid on pass.
REQ-009 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-010 SHALL hold a 4-bit storage register R; d_out = R at all times.
REQ-011 SHALL apply R_next & ~inj_sa0 on every load of R, functional or BIST.
REQ-012 SHALL implement FSM states IDLE, WRITE, CHECK, DONE; a 3-bit pattern index idx; and a sticky fail flag.
REQ-013 SHALL use the pattern table idx 0..7 = 0x0, 0xF, 0x5, 0xA, 0x1, 0x2, 0x4, 0x8.
REQ-014 Functional mode (bist_on=0, any state): each edge R <= d_in (1-cycle latency); FSM -> IDLE.
REQ-015 IDLE with bist_on=1 at an edge: clear pass, bist_done and fail; idx <= 0; -> WRITE; R unchanged.
REQ-016 WRITE: R <= pattern[idx]; -> CHECK.
REQ-017 CHECK: if R != pattern[idx], set fail; if idx==7 -> DONE and bist_done <= 1, pass <= ~fail_next; else idx <= idx+1, -> WRITE.
REQ-018 Total run SHALL take 17 edges from the first edge with bist_on=1 to bist_done=1.
REQ-019 DONE with bist_on=1: hold R, pass and bist_done.
REQ-020 bist_on falling in DONE: return to functional mode; pass and bist_done keep their values until the next run starts or reset.
REQ-021 bist_on falling mid-run (WRITE/CHECK): abort; pass=0, bist_done=0; functional load occurs on that edge.
REQ-022 A new run SHALL begin only from IDLE, so bist_on must be low for at least one edge between runs.
REQ-023 Functional-mode writes SHALL never alter pass or bist_done.

Reset
REQ-024 rst_n=0 SHALL immediately force R=0x0, d_out=0x0, pass=0, bist_done=0, fail=0, idx=0, state IDLE, independent of clk.
REQ-025 Reset asserted mid-run SHALL abort the run with the same values; after release, a run starts only on an edge with bist_on=1.

Verification
REQ-026 Reset then hold rst_n=0 for 2 edges with d_in=0x9 -> d_out=0x0, pass=0, bist_done=0.
REQ-027 bist_on=1, inj_sa0=0x0 -> bist_done=0 for edges 1-16, bist_done=1 and pass=1 after edge 17; then bist_on=0, d_in=0x7, one edge -> d_out=0x7, pass=1.
REQ-028 bist_on=1, inj_sa0=0x1 -> after edge 17 bist_done=1, pass=0.
REQ-029 Start a run, drop bist_on after edge 6 with d_in=0xC -> d_out=0xC, bist_done=0, pass=0; a re-run with inj_sa0=0 then yields pass=1.
REQ-030 Functional mode: d_in sequence 0x3, 0xE, 0x0 -> d_out follows one edge later.
REQ-031 Assert rst_n=0 at edge 10 of a run -> all outputs 0 immediately.

Source files
------------

// File: rtl/register_bist.sv
// ---------------------------------------------------------------------------
// register_bist
//
// A 4-bit storage register with a built-in self-test engine. In functional
// mode the register simply captures d_in on every clock edge. While bist_on
// is high, the engine walks an 8-entry pattern table. For each pattern it
// writes the pattern into the register, then reads it back and compares.
// Any mismatch sets a sticky fail flag. After the last pattern the result is
// published on pass and bist_done, and both are held until the next run
// starts or reset is asserted.
//
// inj_sa0 is a test-only hook. Each set bit forces the matching register
// bit to 0 on every load, so the self-test can be shown to catch a
// stuck-at-0 fault. Tie it to zero in normal use.
//
// Ports:
//   clk        in   1  rising-edge clock for all state
//   rst_n      in   1  asynchronous, active-low reset
//   d_in       in   4  functional write data
//   bist_on    in   1  1 = run/hold self-test, 0 = functional mode
//   inj_sa0    in   4  stuck-at-0 fault injection mask
//   d_out      out  4  current register contents (registered)
//   pass       out  1  last completed self-test found no mismatch
//   bist_done  out  1  a self-test has completed, pass is valid
// ---------------------------------------------------------------------------
module register_bist (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d_in,
  input  logic       bist_on,
  input  logic [3:0] inj_sa0,
  output logic [3:0] d_out,
  output logic       pass,
  output logic       bist_done
);

  // Self-test sequencer states. Each pattern takes one WRITE edge and one
  // CHECK edge. With the single IDLE start edge, a full run is 1 + 8*2 = 17
  // edges long.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } bistState_t;

  bistState_t r_state;
  logic [2:0] r_idx;
  logic       r_failSticky;
  logic [3:0] r_data;
  logic       r_pass;
  logic       r_done;

  bistState_t w_stateNext;
  logic [2:0] w_idxNext;
  logic       w_failNext;
  logic       w_loadEn;
  logic [3:0] w_loadData;
  logic [3:0] w_dataNext;
  logic       w_passNext;
  logic       w_doneNext;
  logic [3:0] w_pattern;
  logic       w_mismatch;

  // Pattern table. It starts with all-zeros and all-ones, then two
  // checkerboards, then a walking one. Together these exercise every bit in
  // both polarities and catch adjacent-bit coupling.
  function automatic logic [3:0] patternAt(input logic [2:0] idx);
    logic [3:0] pat;
    case (idx)
      3'd0:    pat = 4'h0;
      3'd1:    pat = 4'hF;
      3'd2:    pat = 4'h5;
      3'd3:    pat = 4'hA;
      3'd4:    pat = 4'h1;
      3'd5:    pat = 4'h2;
      3'd6:    pat = 4'h4;
      default: pat = 4'h8;
    endcase
    return pat;
  endfunction

  // The current pattern and the read-back comparison are shared by the
  // WRITE state (which loads the pattern) and the CHECK state (which
  // compares the register against it).
  always_comb begin
    w_pattern  = patternAt(r_idx);
    w_mismatch = (r_data != w_pattern);
  end

  // Next-state and next-value logic for the sequencer and the register.
  // Every target starts at "hold", and each branch overrides only what it
  // changes.
  //
  // Dropping bist_on always wins. It forces a functional load and a return
  // to IDLE. If a run was in progress, the partial result is discarded.
  // If the run had finished, pass and bist_done are kept so software can
  // read them after leaving test mode.
  always_comb begin
    w_stateNext = r_state;
    w_idxNext   = r_idx;
    w_failNext  = r_failSticky;
    w_loadEn    = 1'b0;
    w_loadData  = r_data;
    w_passNext  = r_pass;
    w_doneNext  = r_done;

    if (!bist_on) begin
      w_stateNext = IDLE;
      w_loadEn    = 1'b1;
      w_loadData  = d_in;
      if ((r_state == WRITE) || (r_state == CHECK)) begin
        w_passNext = 1'b0;
        w_doneNext = 1'b0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          w_passNext  = 1'b0;
          w_doneNext  = 1'b0;
          w_failNext  = 1'b0;
          w_idxNext   = 3'd0;
          w_stateNext = WRITE;
        end
        WRITE: begin
          w_loadEn    = 1'b1;
          w_loadData  = w_pattern;
          w_stateNext = CHECK;
        end
        CHECK: begin
          w_failNext = r_failSticky | w_mismatch;
          if (r_idx == 3'd7) begin
            w_stateNext = DONE;
            w_doneNext  = 1'b1;
            w_passNext  = ~w_failNext;
          end else begin
            w_idxNext   = r_idx + 3'd1;
            w_stateNext = WRITE;
          end
        end
        DONE: begin
          w_stateNext = DONE;
        end
        default: begin
          w_stateNext = IDLE;
        end
      endcase
    end
  end

  // The stuck-at-0 mask is applied on the load path itself. That way a
  // functional write and a pattern write see exactly the same fault.
  always_comb begin
    w_dataNext = w_loadEn ? (w_loadData & ~inj_sa0) : r_data;
  end

  // State register for the sequencer, the storage register and the result
  // flags. Reset is asynchronous, so the outputs clear as soon as rst_n
  // falls, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_idx        <= 3'd0;
      r_failSticky <= 1'b0;
      r_data       <= 4'h0;
      r_pass       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_idx        <= w_idxNext;
      r_failSticky <= w_failNext;
      r_data       <= w_dataNext;
      r_pass       <= w_passNext;
      r_done       <= w_doneNext;
    end
  end

  // All outputs come straight from flops.
  assign d_out     = r_data;
  assign pass      = r_pass;
  assign bist_done = r_done;

endmodule

// File: tb/tb_register_bist.sv
// ---------------------------------------------------------------------------
// tb_register_bist
//
// Directed bench for register_bist. Each stimulus step pushes the outputs
// expected after the next clock edge onto a queue. After that edge, the
// entry is popped and compared against the DUT outputs. Expected register
// contents come from a small bench-side model: the pattern table, the
// injection mask and the last value loaded.
// ---------------------------------------------------------------------------
module tb_register_bist;

  logic       clk;
  logic       rst_n;
  logic [3:0] d_in;
  logic       bist_on;
  logic [3:0] inj_sa0;
  logic [3:0] d_out;
  logic       pass;
  logic       bist_done;

  typedef struct {
    string      tag;
    logic [3:0] dOut;
    logic       pass;
    logic       done;
  } expect_t;

  expect_t    expQueue[$];
  int         testsRun  = 0;
  int         failCount = 0;
  logic [3:0] modelR;
  logic [3:0] patTable[8];

  register_bist dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_in      (d_in),
    .bist_on   (bist_on),
    .inj_sa0   (inj_sa0),
    .d_out     (d_out),
    .pass      (pass),
    .bist_done (bist_done)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog, so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [3:0] din, input logic bist, input logic [3:0] inj);
    d_in    = din;
    bist_on = bist;
    inj_sa0 = inj;
  endtask

  task automatic pushExpect(input string tag, input logic [3:0] dExp, input logic pExp, input logic bExp);
    expect_t e;
    e.tag  = tag;
    e.dOut = dExp;
    e.pass = pExp;
    e.done = bExp;
    expQueue.push_back(e);
  endtask

  // Pops one expected entry and compares all three outputs against it.
  task automatic checkOutput();
    expect_t e;
    testsRun++;
    assert (expQueue.size() != 0) else begin
      failCount++;
      $error("[TB] FAIL scoreboard: queue empty, got 0 entries, required 1");
    end
    if (expQueue.size() != 0) begin
      e = expQueue.pop_front();
      testsRun++;
      assert (d_out === e.dOut) else begin
        failCount++;
        $error("[TB] FAIL %s d_out: got %h, required %h", e.tag, d_out, e.dOut);
      end
      testsRun++;
      assert (pass === e.pass) else begin
        failCount++;
        $error("[TB] FAIL %s pass: got %b, required %b", e.tag, pass, e.pass);
      end
      testsRun++;
      assert (bist_done === e.done) else begin
        failCount++;
        $error("[TB] FAIL %s bist_done: got %b, required %b", e.tag, bist_done, e.done);
      end
    end
  endtask

  // Advances one edge and samples the outputs 1 unit after it.
  task automatic tickAndCheck();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // A single functional-mode edge.
  task automatic funcStep(input string tag, input logic [3:0] din, input logic [3:0] inj,
                          input logic pExp, input logic bExp);
    applyStimulus(din, 1'b0, inj);
    modelR = din & ~inj;
    pushExpect(tag, modelR, pExp, bExp);
    tickAndCheck();
  endtask

  // Runs nEdges edges with bist_on held high, starting from IDLE.
  // Edge 1 clears the result flags and leaves the register alone.
  // Edge 2k+2 writes pattern k, masked by the injected faults.
  // Edge 17 publishes the result. The run passes only if no pattern is
  // corrupted by the mask.
  task automatic runBist(input string tag, input int nEdges, input logic [3:0] inj);
    logic expPass;
    expPass = 1'b1;
    for (int k = 0; k < 8; k++)
      if ((patTable[k] & ~inj) != patTable[k]) expPass = 1'b0;
    applyStimulus(4'h0, 1'b1, inj);
    for (int e = 1; e <= nEdges; e++) begin
      if (e >= 2) modelR = patTable[(e - 2) / 2] & ~inj;
      if (e == 17) pushExpect(tag, modelR, expPass, 1'b1);
      else         pushExpect(tag, modelR, 1'b0, 1'b0);
      tickAndCheck();
    end
  endtask

  initial begin
    patTable[0] = 4'h0; patTable[1] = 4'hF; patTable[2] = 4'h5; patTable[3] = 4'hA;
    patTable[4] = 4'h1; patTable[5] = 4'h2; patTable[6] = 4'h4; patTable[7] = 4'h8;

    // Reset held for two edges with data on d_in: everything stays zero.
    rst_n = 1'b1;
    applyStimulus(4'h9, 1'b0, 4'h0);
    #2 rst_n = 1'b0;
    modelR = 4'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    pushExpect("reset_hold", 4'h0, 1'b0, 1'b0);
    checkOutput();
    rst_n = 1'b1;

    // Functional mode: d_out follows d_in one edge later.
    funcStep("func_3", 4'h3, 4'h0, 1'b0, 1'b0);
    funcStep("func_E", 4'hE, 4'h0, 1'b0, 1'b0);
    funcStep("func_0", 4'h0, 4'h0, 1'b0, 1'b0);

    // Clean run: passes after edge 17.
    runBist("run_clean", 17, 4'h0);
    // DONE with bist_on still high: everything holds.
    pushExpect("done_hold", modelR, 1'b1, 1'b1);
    tickAndCheck();
    // Leaving test mode keeps the result and loads d_in.
    funcStep("exit_done", 4'h7, 4'h0, 1'b1, 1'b1);

    // Stuck-at-0 on bit 0: run must fail.
    runBist("run_sa0", 17, 4'h1);
    funcStep("exit_fail", 4'hD, 4'h0, 1'b0, 1'b1);

    // Abort after edge 6 with d_in = C.
    runBist("run_abort", 6, 4'h0);
    funcStep("abort", 4'hC, 4'h0, 1'b0, 1'b0);
    runBist("rerun", 17, 4'h0);
    funcStep("exit_rerun", 4'h5, 4'h0, 1'b1, 1'b1);

    // Reset falls between edges 9 and 10 of a run: clears immediately.
    runBist("run_reset", 9, 4'h0);
    #3 rst_n = 1'b0;
    #1;
    modelR = 4'h0;
    pushExpect("async_reset", 4'h0, 1'b0, 1'b0);
    checkOutput();
    pushExpect("reset_edge", 4'h0, 1'b0, 1'b0);
    tickAndCheck();
    rst_n = 1'b1;
    // After release, a run starts on the first edge with bist_on high.
    runBist("run_after_reset", 17, 4'h0);

    assert (expQueue.size() == 0) else begin
      failCount++;
      $error("[TB] FAIL scoreboard_drain: got %0d entries left, required 0", expQueue.size());
    end
    testsRun++;

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
